// File: rtl/module_captura_operandos_pkg.sv
// Shared types and key decoding for the keypad operand-capture path.
package pkg_teclado;

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_DONE
  } state_t;

  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/module_bcd_shift.sv
// One BCD operand register: shifts a new digit in at the LSD, counts digits, saturates at NDIG.
module module_bcd_shift #(
  parameter int NDIG = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        shift_en,
  input  logic [3:0]                  digit,
  output logic [4*NDIG-1:0]           value,
  output logic [$clog2(NDIG+1)-1:0]   count,
  output logic                        full
);

  localparam int CW = $clog2(NDIG + 1);

  logic [4*NDIG-1:0] w_shifted;

  // Built by shift-then-overwrite so the same code works for NDIG = 1.
  always_comb begin
    w_shifted      = value << 4;
    w_shifted[3:0] = digit;
  end

  assign full = (count == CW'(NDIG));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      count <= '0;
    end else if (shift_en && !full) begin
      value <= w_shifted;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/module_captura_operandos.sv
// Keypad operand capture: entry FSM, two BCD operand registers, display mux and pulses.
module module_captura_operandos
  import pkg_teclado::*;
#(
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          key_code,
  input  logic                key_valid,
  output logic [4*NDIG-1:0]   op_a,
  output logic [4*NDIG-1:0]   op_b,
  output logic                operands_ready,
  output logic [4*NDIG-1:0]   disp_bcd,
  output logic [NDIG-1:0]     disp_en,
  output logic                sel_b,
  output logic                key_err
);

  localparam int CW = $clog2(NDIG + 1);

  state_t          r_state, w_state_n;
  logic [CW-1:0]   w_cnt_a, w_cnt_b, w_cnt_disp;
  logic            w_full_a, w_full_b;
  logic            w_shift_a, w_shift_b, w_clr_a, w_clr_b;
  logic            w_err_n, w_rdy_n;
  logic            w_digit, w_enter, w_clear, w_bad;

  assign w_digit = key_valid && is_digit(key_code);
  assign w_enter = key_valid && (key_code == KEY_ENTER);
  assign w_clear = key_valid && (key_code == KEY_CLEAR);
  assign w_bad   = key_valid && !is_digit(key_code)
                   && (key_code != KEY_ENTER) && (key_code != KEY_CLEAR);

  module_bcd_shift #(.NDIG(NDIG)) u_op_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr_a),
    .shift_en (w_shift_a),
    .digit    (key_code),
    .value    (op_a),
    .count    (w_cnt_a),
    .full     (w_full_a)
  );

  module_bcd_shift #(.NDIG(NDIG)) u_op_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr_b),
    .shift_en (w_shift_b),
    .digit    (key_code),
    .value    (op_b),
    .count    (w_cnt_b),
    .full     (w_full_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_A;
      key_err        <= 1'b0;
      operands_ready <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      key_err        <= w_err_n;
      operands_ready <= w_rdy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_a = 1'b0;
    w_shift_b = 1'b0;
    w_clr_a   = 1'b0;
    w_clr_b   = 1'b0;
    w_err_n   = 1'b0;
    w_rdy_n   = 1'b0;
    if (w_clear) begin
      w_clr_a   = 1'b1;
      w_clr_b   = 1'b1;
      w_state_n = S_A;
    end else if (w_bad) begin
      w_err_n = 1'b1;
    end else begin
      case (r_state)
        S_A: begin
          if (w_digit) begin
            if (w_full_a) w_err_n = 1'b1;
            else          w_shift_a = 1'b1;
          end else if (w_enter) begin
            if (w_cnt_a != '0) begin
              w_state_n = S_B;
              w_clr_b   = 1'b1;
            end else begin
              w_err_n = 1'b1;
            end
          end
        end
        S_B: begin
          if (w_digit) begin
            if (w_full_b) w_err_n = 1'b1;
            else          w_shift_b = 1'b1;
          end else if (w_enter) begin
            if (w_cnt_b != '0) begin
              w_state_n = S_DONE;
              w_rdy_n   = 1'b1;
            end else begin
              w_err_n = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (w_digit || w_enter) w_err_n = 1'b1;
        end
        default: w_state_n = S_A;
      endcase
    end
  end

  // Leading zeros blanked; digit 0 always lit even with an empty operand.
  always_comb begin
    sel_b      = (r_state != S_A);
    disp_bcd   = sel_b ? op_b : op_a;
    w_cnt_disp = sel_b ? w_cnt_b : w_cnt_a;
    disp_en    = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      disp_en[i] = (i == 0) || (i < 32'(w_cnt_disp));
    end
  end

endmodule

// File: tb/tb_module_captura_operandos.sv
// Directed bench for module_captura_operandos with NDIG = 3.
module tb_module_captura_operandos;

  localparam int NDIG = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        key_code = 4'h0;
  logic              key_valid = 1'b0;
  logic [4*NDIG-1:0] op_a, op_b, disp_bcd;
  logic [NDIG-1:0]   disp_en;
  logic              operands_ready, sel_b, key_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  module_captura_operandos #(.NDIG(NDIG)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .op_a           (op_a),
    .op_b           (op_b),
    .operands_ready (operands_ready),
    .disp_bcd       (disp_bcd),
    .disp_en        (disp_en),
    .sel_b          (sel_b),
    .key_err        (key_err)
  );

  // Called at a negedge; returns at the next negedge with the key's effect visible.
  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (op_a !== 12'h000) $display("FAIL reset_op_a: got %h expected %h", op_a, 12'h000); else n_pass++;
    n_checks++; if (op_b !== 12'h000) $display("FAIL reset_op_b: got %h expected %h", op_b, 12'h000); else n_pass++;
    n_checks++; if (disp_bcd !== 12'h000) $display("FAIL reset_disp_bcd: got %h expected %h", disp_bcd, 12'h000); else n_pass++;
    n_checks++; if (disp_en !== 3'b001) $display("FAIL reset_disp_en: got %b expected %b", disp_en, 3'b001); else n_pass++;
    n_checks++; if (sel_b !== 1'b0) $display("FAIL reset_sel_b: got %b expected %b", sel_b, 1'b0); else n_pass++;
    n_checks++; if (operands_ready !== 1'b0) $display("FAIL reset_ready: got %b expected %b", operands_ready, 1'b0); else n_pass++;
    n_checks++; if (key_err !== 1'b0) $display("FAIL reset_key_err: got %b expected %b", key_err, 1'b0); else n_pass++;
    key_code = 4'h5;
    @(negedge clk);
    key_code = 4'h0;
    n_checks++; if (op_a !== 12'h000) $display("FAIL novalid_op_a: got %h expected %h", op_a, 12'h000); else n_pass++;
  endtask

  task automatic test_digits();
    do_reset();
    press(4'h1);
    n_checks++; if (op_a !== 12'h001) $display("FAIL dig1_op_a: got %h expected %h", op_a, 12'h001); else n_pass++;
    n_checks++; if (disp_en !== 3'b001) $display("FAIL dig1_disp_en: got %b expected %b", disp_en, 3'b001); else n_pass++;
    press(4'h2);
    n_checks++; if (op_a !== 12'h012) $display("FAIL dig2_op_a: got %h expected %h", op_a, 12'h012); else n_pass++;
    n_checks++; if (disp_en !== 3'b011) $display("FAIL dig2_disp_en: got %b expected %b", disp_en, 3'b011); else n_pass++;
    press(4'h3);
    n_checks++; if (key_err !== 1'b0) $display("FAIL dig3_key_err: got %b expected %b", key_err, 1'b0); else n_pass++;
    n_checks++; if (disp_en !== 3'b111) $display("FAIL dig3_disp_en: got %b expected %b", disp_en, 3'b111); else n_pass++;
    press(4'h4);
    n_checks++; if (key_err !== 1'b1) $display("FAIL dig4_key_err: got %b expected %b", key_err, 1'b1); else n_pass++;
    n_checks++; if (op_a !== 12'h123) $display("FAIL dig4_op_a: got %h expected %h", op_a, 12'h123); else n_pass++;
    press(4'h5);
    n_checks++; if (op_a !== 12'h123) $display("FAIL sat_op_a: got %h expected %h", op_a, 12'h123); else n_pass++;
    n_checks++; if (disp_en !== 3'b111) $display("FAIL sat_disp_en: got %b expected %b", disp_en, 3'b111); else n_pass++;
    @(negedge clk);
    n_checks++; if (key_err !== 1'b0) $display("FAIL err_pulse_len: got %b expected %b", key_err, 1'b0); else n_pass++;
  endtask

  task automatic test_operands();
    do_reset();
    press(4'h4);
    n_checks++; if (op_a !== 12'h004) $display("FAIL opA_value: got %h expected %h", op_a, 12'h004); else n_pass++;
    press(4'hE);
    n_checks++; if (sel_b !== 1'b1) $display("FAIL enterA_sel_b: got %b expected %b", sel_b, 1'b1); else n_pass++;
    n_checks++; if (disp_bcd !== 12'h000) $display("FAIL enterA_disp_bcd: got %h expected %h", disp_bcd, 12'h000); else n_pass++;
    n_checks++; if (disp_en !== 3'b001) $display("FAIL enterA_disp_en: got %b expected %b", disp_en, 3'b001); else n_pass++;
    n_checks++; if (operands_ready !== 1'b0) $display("FAIL enterA_ready: got %b expected %b", operands_ready, 1'b0); else n_pass++;
    press(4'h7);
    n_checks++; if (op_b !== 12'h007) $display("FAIL opB_value: got %h expected %h", op_b, 12'h007); else n_pass++;
    n_checks++; if (op_a !== 12'h004) $display("FAIL opB_op_a_hold: got %h expected %h", op_a, 12'h004); else n_pass++;
    press(4'hE);
    n_checks++; if (operands_ready !== 1'b1) $display("FAIL enterB_ready: got %b expected %b", operands_ready, 1'b1); else n_pass++;
    n_checks++; if (disp_bcd !== 12'h007) $display("FAIL enterB_disp_bcd: got %h expected %h", disp_bcd, 12'h007); else n_pass++;
    n_checks++; if (sel_b !== 1'b1) $display("FAIL enterB_sel_b: got %b expected %b", sel_b, 1'b1); else n_pass++;
    @(negedge clk);
    n_checks++; if (operands_ready !== 1'b0) $display("FAIL ready_pulse_len: got %b expected %b", operands_ready, 1'b0); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    press(4'hE);
    n_checks++; if (key_err !== 1'b1) $display("FAIL emptyA_key_err: got %b expected %b", key_err, 1'b1); else n_pass++;
    n_checks++; if (sel_b !== 1'b0) $display("FAIL emptyA_sel_b: got %b expected %b", sel_b, 1'b0); else n_pass++;
    press(4'h2);
    press(4'hE);
    press(4'hE);
    n_checks++; if (key_err !== 1'b1) $display("FAIL emptyB_key_err: got %b expected %b", key_err, 1'b1); else n_pass++;
    n_checks++; if (sel_b !== 1'b1) $display("FAIL emptyB_sel_b: got %b expected %b", sel_b, 1'b1); else n_pass++;
    n_checks++; if (operands_ready !== 1'b0) $display("FAIL emptyB_ready: got %b expected %b", operands_ready, 1'b0); else n_pass++;
    press(4'hB);
    n_checks++; if (key_err !== 1'b1) $display("FAIL keyB_key_err: got %b expected %b", key_err, 1'b1); else n_pass++;
    n_checks++; if (op_a !== 12'h002) $display("FAIL keyB_op_a: got %h expected %h", op_a, 12'h002); else n_pass++;
    n_checks++; if (op_b !== 12'h000) $display("FAIL keyB_op_b: got %h expected %h", op_b, 12'h000); else n_pass++;
  endtask

  task automatic test_done_clear();
    do_reset();
    press(4'h4); press(4'hE); press(4'h7); press(4'hE);
    press(4'h5);
    n_checks++; if (key_err !== 1'b1) $display("FAIL done_digit_key_err: got %b expected %b", key_err, 1'b1); else n_pass++;
    n_checks++; if (op_b !== 12'h007) $display("FAIL done_op_b_hold: got %h expected %h", op_b, 12'h007); else n_pass++;
    n_checks++; if (op_a !== 12'h004) $display("FAIL done_op_a_hold: got %h expected %h", op_a, 12'h004); else n_pass++;
    press(4'hE);
    n_checks++; if (key_err !== 1'b1) $display("FAIL done_enter_key_err: got %b expected %b", key_err, 1'b1); else n_pass++;
    n_checks++; if (operands_ready !== 1'b0) $display("FAIL done_enter_ready: got %b expected %b", operands_ready, 1'b0); else n_pass++;
    press(4'hF);
    n_checks++; if (key_err !== 1'b0) $display("FAIL clear_key_err: got %b expected %b", key_err, 1'b0); else n_pass++;
    n_checks++; if (op_a !== 12'h000) $display("FAIL clear_op_a: got %h expected %h", op_a, 12'h000); else n_pass++;
    n_checks++; if (op_b !== 12'h000) $display("FAIL clear_op_b: got %h expected %h", op_b, 12'h000); else n_pass++;
    n_checks++; if (sel_b !== 1'b0) $display("FAIL clear_sel_b: got %b expected %b", sel_b, 1'b0); else n_pass++;
    n_checks++; if (disp_en !== 3'b001) $display("FAIL clear_disp_en: got %b expected %b", disp_en, 3'b001); else n_pass++;
    press(4'h6);
    n_checks++; if (op_a !== 12'h006) $display("FAIL after_clear_op_a: got %h expected %h", op_a, 12'h006); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    key_valid = 1'b1;
    key_code  = 4'h9;
    @(negedge clk);
    n_checks++; if (op_a !== 12'h009) $display("FAIL b2b_first_op_a: got %h expected %h", op_a, 12'h009); else n_pass++;
    key_code = 4'h8;
    @(negedge clk);
    key_code = 4'hE;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    n_checks++; if (op_a !== 12'h098) $display("FAIL b2b_op_a: got %h expected %h", op_a, 12'h098); else n_pass++;
    n_checks++; if (sel_b !== 1'b1) $display("FAIL b2b_sel_b: got %b expected %b", sel_b, 1'b1); else n_pass++;
    n_checks++; if (disp_en !== 3'b001) $display("FAIL b2b_disp_en: got %b expected %b", disp_en, 3'b001); else n_pass++;
  endtask

  task automatic test_reset_with_key();
    do_reset();
    press(4'h5);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h6;
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    n_checks++; if (op_a !== 12'h000) $display("FAIL rstkey_op_a: got %h expected %h", op_a, 12'h000); else n_pass++;
    n_checks++; if (disp_en !== 3'b001) $display("FAIL rstkey_disp_en: got %b expected %b", disp_en, 3'b001); else n_pass++;
    n_checks++; if (key_err !== 1'b0) $display("FAIL rstkey_key_err: got %b expected %b", key_err, 1'b0); else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_digits();
    test_operands();
    test_errors();
    test_done_clear();
    test_back_to_back();
    test_reset_with_key();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
